imem_fetch_port: RTL and testbench
==================================

# imem_fetch_port

Parametrised, pipelined instruction memory for the RV32 fetch stage, replacing the fixed 2 KiB single-port array. It accepts word-address fetch requests over a valid/ready handshake, returns instruction words one cycle later through a 2-entry response buffer that absorbs decode back-pressure, and flags out-of-range fetches. A separate write port allows program loading at run time.

## Interface
Parameters:
- BASE_ADDR, 32'h0100_0000, byte base address of the array; must be aligned to 4*DEPTH_WORDS
- DEPTH_WORDS, 512, number of 32-bit words; power of two, 16..65536
- FAULT_INSTR, 32'h0000_0013, word returned on a faulting fetch (RV32 NOP)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  fetch request present
- req_ready  output  1  request can be accepted this cycle
- req_addr  input  30  word address, byte address bits [31:2]
- rsp_valid  output  1  response word available
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_instr  output  32  instruction word
- rsp_addr  output  30  word address of this response
- rsp_fault  output  1  req_addr was outside the array
- flush  input  1  discard all in-flight and buffered responses
- wr_en  input  1  program-load write strobe
- wr_addr  input  30  word address of the write
- wr_data  input  32  write data
- wr_be  input  4  byte enables; bit i writes wr_data[8i+7:8i]

## Operation
- Array index is req_addr[log2(DEPTH_WORDS)-1:0]. A request is in range iff req_addr[29:log2(DEPTH_WORDS)] == BASE_ADDR[31:2+log2(DEPTH_WORDS)].
- Request accept: req_valid && req_ready. The array is read on that edge. The result {instr, addr, fault} is pushed into the response buffer on the next edge.
- Response buffer: 2-entry FIFO with occupancy count 0..2, counting both entries and the in-flight read. rsp_valid = (buffered entries > 0) && !flush. The head is popped on rsp_valid && rsp_ready.
- req_ready = (count != 2) && !flush. It has no combinational dependence on rsp_ready. Push and pop in the same cycle leave the count unchanged, giving full throughput at one fetch per cycle.
- Out-of-range fetch: rsp_fault=1, rsp_instr=FAULT_INSTR, and rsp_addr is the requested address. The array is not read.
- Flush: while asserted, req_ready=0 and rsp_valid=0. On that edge the count and the in-flight read are cleared and nothing is pushed. Output resumes on the first request after deassertion.
- Writes take effect on the edge where wr_en=1 and the address is in range. Only enabled bytes change. Out-of-range writes are silently dropped.
- Read/write to the same word on the same edge is read-first: the fetch returns the old data.
- Array contents are not reset and power up undefined.

## Timing
- Reset (rst_n low, asynchronous): count=0, the in-flight flag is cleared, rsp_valid=0, rsp_instr=0, rsp_addr=0, and rsp_fault=0. req_ready=1 from the first cycle after rst_n rises.
- Latency: request accepted at edge N gives rsp_valid high after edge N+1, with data stable until popped.
- rsp_instr, rsp_addr and rsp_fault hold steady while rsp_valid && !rsp_ready. These are AXI-style stable rules.
- Reset asserted mid-stream drops all buffered and in-flight responses, and does not alter array contents.
- Simultaneous flush and rsp_ready: no pop is counted. Flush wins.
- Simultaneous flush and req_valid: the request is not accepted, because req_ready=0.

## Test plan
- Preload words 0..3 via the write port with 32'h11111111 × index, then stream fetches of 0x0400000..0x0400003 with rsp_ready=1. Responses arrive one cycle after each accept, back-to-back, with matching rsp_addr.
- Hold rsp_ready=0 and issue three requests. The first two are accepted, req_ready drops to 0, and rsp_instr stays stable. Release rsp_ready and all responses emerge in order with no loss or duplication.
- Fetch word address 0x0400200 (one beyond the end) and 0x0000000. Each gives rsp_fault=1 and rsp_instr=32'h00000013.
- Write wr_be=4'b0101 with wr_data=32'hAABBCCDD over 32'h0 while fetching the same word in that cycle. The fetch returns 32'h0, and the next fetch returns 32'h00BB00DD.
- Fill the buffer to 2, pulse flush for one cycle together with req_valid. rsp_valid=0 in the flush cycle and the next one, and no stale response appears. A new fetch then completes normally.
- Assert rst_n=0 asynchronously between edges with 2 entries buffered. The outputs clear immediately, and previously written array data is still readable after reset.

Source files
------------

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: pipelined instruction memory for the RV32 fetch stage.
// Requests are accepted over valid/ready, the array is read on the accept
// edge and the result lands in a 2-entry response buffer one edge later.
// A byte-enabled write port loads the program at run time.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid && ready. The request side never depends combinationally on
// rsp_ready. Response payload holds steady while rsp_valid && !rsp_ready.
// flush suppresses both ready and valid and wins over everything else.
module imem_fetch_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter logic [31:0] FAULT_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [29:0] rsp_addr,
    output logic        rsp_fault,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [29:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [29-AW:0] BASE_TAG = BASE_ADDR[31:2+AW];

    logic [31:0] mem [DEPTH_WORDS];

    // Read stage: one fetch in flight between the accept edge and the push edge
    logic        inflight_q;
    logic [31:0] rd_data_q;
    logic [29:0] rd_addr_q;
    logic        rd_fault_q;

    // Response buffer: two entries, read/write pointers, occupancy includes in-flight
    logic [31:0] buf_instr_q [2];
    logic [29:0] buf_addr_q  [2];
    logic        buf_fault_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [1:0]  buf_cnt;

    logic        rd_in_range;
    logic        wr_in_range;
    logic        accept;
    logic        pop;

    assign rd_in_range = (req_addr[29:AW] == BASE_TAG);
    assign wr_in_range = (wr_addr[29:AW] == BASE_TAG);

    assign buf_cnt   = cnt_q - {1'b0, inflight_q};
    assign req_ready = (cnt_q != 2'd2) && !flush;
    assign rsp_valid = (buf_cnt != 2'd0) && !flush;
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_instr = buf_instr_q[rd_ptr_q];
    assign rsp_addr  = buf_addr_q[rd_ptr_q];
    assign rsp_fault = buf_fault_q[rd_ptr_q];

    // Occupancy update: accept adds, pop removes, both together cancel
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !accept) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    // Array: read-first fetch port and byte-enabled program-load port, no reset
    always_ff @(posedge clk) begin
        if (accept && rd_in_range) begin
            rd_data_q <= mem[req_addr[AW-1:0]];
        end
        if (wr_en && wr_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr[AW-1:0]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Control path: in-flight tracking, buffer push/pop, flush clears everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q     <= 1'b0;
            rd_addr_q      <= '0;
            rd_fault_q     <= 1'b0;
            cnt_q          <= 2'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            buf_instr_q[0] <= '0;
            buf_instr_q[1] <= '0;
            buf_addr_q[0]  <= '0;
            buf_addr_q[1]  <= '0;
            buf_fault_q[0] <= 1'b0;
            buf_fault_q[1] <= 1'b0;
        end else if (flush) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            inflight_q <= accept;
            cnt_q      <= cnt_d;
            if (accept) begin
                rd_addr_q  <= req_addr;
                rd_fault_q <= !rd_in_range;
            end
            if (inflight_q) begin
                buf_instr_q[wr_ptr_q] <= rd_fault_q ? FAULT_INSTR : rd_data_q;
                buf_addr_q[wr_ptr_q]  <= rd_addr_q;
                buf_fault_q[wr_ptr_q] <= rd_fault_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: directed scenarios, a transaction-level model
// (queue of outstanding responses plus a word array) checked every cycle, and
// literal expectations on the sequence of consumed responses.
module tb_imem_fetch_port;

    localparam int          DEPTH = 512;
    localparam logic [29:0] W0    = 30'h0400000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [29:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [29:0] rsp_addr;
    logic        rsp_fault;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [29:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;

    imem_fetch_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_fault (rsp_fault),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be)
    );

    // Clock
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [29:0] addr;
        logic        fault;
        int          avail;
    } rsp_t;

    rsp_t        mdl_q[$];
    logic [31:0] mdl_mem [DEPTH];
    int          cyc = 0;
    logic [32:0] log_q[$];
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [29:0] a);
        return (a >> 9) == 30'h2000;
    endfunction

    // Model: outstanding responses ordered by acceptance, each visible one edge after accept
    initial begin
        rsp_t r;
        bit   er, ev, acc, pp;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                er  = (mdl_q.size() != 2) && !flush;
                ev  = (mdl_q.size() > 0) && (mdl_q[0].avail <= cyc) && !flush;
                acc = req_valid && er;
                pp  = ev && rsp_ready;
                if (flush) begin
                    mdl_q.delete();
                end else begin
                    if (pp) void'(mdl_q.pop_front());
                    if (acc) begin
                        r.addr  = req_addr;
                        r.fault = !in_rng(req_addr);
                        r.instr = r.fault ? 32'h0000_0013 : mdl_mem[req_addr[8:0]];
                        r.avail = cyc + 2;
                        mdl_q.push_back(r);
                    end
                end
                if (wr_en && in_rng(wr_addr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) mdl_mem[wr_addr[8:0]][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                cyc++;
            end
        end
    end

    // Reset drops every outstanding response
    initial begin
        forever begin
            @(negedge rst_n);
            mdl_q.delete();
        end
    end

    // Compare process: outputs against the model on every falling edge out of reset
    initial begin
        bit er, ev;
        forever begin
            @(negedge clk);
            if (rst_n && run) begin
                er = (mdl_q.size() != 2) && !flush;
                ev = (mdl_q.size() > 0) && (mdl_q[0].avail <= cyc) && !flush;
                chk("req_ready", {32'b0, req_ready}, {32'b0, er});
                chk("rsp_valid", {32'b0, rsp_valid}, {32'b0, ev});
                if (ev) begin
                    chk("rsp_instr", {1'b0, rsp_instr}, {1'b0, mdl_q[0].instr});
                    chk("rsp_addr", {3'b0, rsp_addr}, {3'b0, mdl_q[0].addr});
                    chk("rsp_fault", {32'b0, rsp_fault}, {32'b0, mdl_q[0].fault});
                    if (rsp_ready) log_q.push_back({rsp_fault, rsp_instr});
                end
            end
        end
    end

    // Driver tasks: all start and end at posedge+1
    task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic fetch(input logic [29:0] a);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("fetch_timeout", 33'd1, 33'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (mdl_q.size() != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 60) chk("drain_timeout", 33'd1, 33'd0);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, 33'(log_q.size()), 33'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk(name, log_q[i], exp_q[i]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", {32'b0, rsp_valid}, 33'd0);
        chk("rst_instr", {1'b0, rsp_instr}, 33'd0);
        chk("rst_addr", {3'b0, rsp_addr}, 33'd0);
        chk("rst_fault", {32'b0, rsp_fault}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // Preload and stream
        for (int i = 0; i < 4; i++) wr(W0 + 30'(i), 32'h1111_1111 * i, 4'hF);
        wr(30'h0000001, 32'hDEAD_BEEF, 4'hF);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) fetch(W0 + 30'(i));
        fetch(W0 + 30'd1);
        drain();
        exp_q = '{33'h0_0000_0000, 33'h0_1111_1111, 33'h0_2222_2222, 33'h0_3333_3333, 33'h0_1111_1111};
        check_log("stream");

        // Back-pressure: two accepted, third waits, head stable
        rsp_ready = 1'b0;
        fetch(W0 + 30'd1);
        fetch(W0 + 30'd2);
        req_valid = 1'b1;
        req_addr  = W0 + 30'd3;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", {32'b0, req_ready}, 33'd0);
            chk("bp_hold", {1'b0, rsp_instr}, 33'h0_1111_1111);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        fetch(W0 + 30'd3);
        drain();
        exp_q = '{33'h0_1111_1111, 33'h0_2222_2222, 33'h0_3333_3333};
        check_log("backpressure");

        // Out-of-range fetches
        fetch(30'h0400200);
        fetch(30'h0000000);
        drain();
        exp_q = '{33'h1_0000_0013, 33'h1_0000_0013};
        check_log("fault");

        // Same-edge write and fetch is read-first
        wr_en = 1'b1; wr_addr = W0; wr_data = 32'hAABB_CCDD; wr_be = 4'b0101;
        fetch(W0);
        wr_en = 1'b0;
        fetch(W0);
        drain();
        exp_q = '{33'h0_0000_0000, 33'h0_00BB_00DD};
        check_log("raw");

        // Flush with a full buffer and a coincident request
        rsp_ready = 1'b0;
        fetch(W0 + 30'd1);
        fetch(W0 + 30'd2);
        flush = 1'b1; req_valid = 1'b1; req_addr = W0 + 30'd3;
        @(negedge clk);
        chk("flush_valid0", {32'b0, rsp_valid}, 33'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid1", {32'b0, rsp_valid}, 33'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check_log("flush_stale");
        fetch(W0 + 30'd3);
        drain();
        exp_q = '{33'h0_3333_3333};
        check_log("after_flush");

        // Asynchronous reset with two entries buffered
        rsp_ready = 1'b0;
        fetch(W0 + 30'd1);
        fetch(W0 + 30'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {32'b0, rsp_valid}, 33'd0);
        chk("arst_instr", {1'b0, rsp_instr}, 33'd0);
        chk("arst_addr", {3'b0, rsp_addr}, 33'd0);
        chk("arst_fault", {32'b0, rsp_fault}, 33'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        fetch(W0 + 30'd2);
        fetch(W0);
        drain();
        exp_q = '{33'h0_2222_2222, 33'h0_00BB_00DD};
        check_log("after_reset");

        repeat (2) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
